raster_pixel_source: RTL and testbench

Parametrised raster-order pixel stream generator with valid/ready output handshake. It produces one IMG_W x IMG_H frame per start pulse in one of four pattern modes and marks start-of-frame, end-of-line and end-of-frame. It generalises the fixed 8-bit counting source used for file-write checks. It feeds the Gaussian blur line buffers and the file-dump benches with known, checkable frames.

---
 rtl/pix_stream_pkg.sv | 22 ++
 rtl/raster_counter.sv | 56 +++++
 rtl/raster_pixel_source.sv | 114 +++++++++++
 tb/tb_raster_pixel_source.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pix_stream_pkg.sv
// Shared pixel-stream types: pattern modes, source states and a counter width helper.
package pix_stream_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_ROW   = 2'd1,
    MODE_COL   = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row position counters for raster-order traversal of one frame.
module raster_counter
  import pix_stream_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  localparam int unsigned CW = cnt_w(IMG_W),
  localparam int unsigned RW = cnt_w(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance_i,
  input  logic          clear_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_col_o,
  output logic          last_row_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last_col_o = (col_q == CW'(IMG_W - 1));
  assign last_row_o = (row_q == RW'(IMG_H - 1));

  // Row wraps after the final line so the counters rest at zero between frames.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_row_o ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/raster_pixel_source.sv
// Raster-order test-frame generator with valid/ready output and frame/line markers.
module raster_pixel_source
  import pix_stream_pkg::*;
#(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 64,
  parameter int unsigned START_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             ready,
  output logic             valid,
  output logic [PIX_W-1:0] pixel,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             last_col, last_row;
  logic             advance, clear;

  raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance),
    .clear_i   (clear),
    .col_o     (col),
    .row_o     (row),
    .last_col_o(last_col),
    .last_row_o(last_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_INC;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pix_d   = pix_q;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode_e'(mode);
          pix_d   = PIX_W'(START_VAL);
          clear   = 1'b1;
        end
      end
      RUN: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready) begin
          advance = 1'b1;
          pix_d   = pix_q + PIX_W'(1);
          if (last_col && last_row) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern select; everything reads zero outside RUN.
  always_comb begin
    pixel = '0;
    if (valid) begin
      case (mode_q)
        MODE_INC:   pixel = pix_q;
        MODE_ROW:   pixel = PIX_W'(row);
        MODE_COL:   pixel = PIX_W'(col);
        MODE_CHECK: pixel = {PIX_W{row[0] ^ col[0]}};
        default:    pixel = '0;
      endcase
    end
  end

  assign sof = valid && (col == '0) && (row == '0);
  assign eol = valid && last_col;
  assign eof = eol && last_row;

endmodule

// File: tb/tb_raster_pixel_source.sv
// Randomised bench for raster_pixel_source against a frame-index reference model.
module tb_raster_pixel_source;

  localparam int IW = 4;
  localparam int IH = 3;
  localparam int NPIX = IW * IH;

  logic       clk, rst, start, ready;
  logic [1:0] mode;

  logic       va, sofa, eola, eofa, busya, donea;
  logic [7:0] pa;
  logic       vw, sofw, eolw, eofw, busyw, donew;
  logic [3:0] pw;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a frame is just a transfer index k; row/col follow by division.
  bit m_run, m_done;
  int m_k, m_mode;
  int cnt_busy, cnt_done;

  raster_pixel_source #(.PIX_W(8), .IMG_W(IW), .IMG_H(IH), .START_VAL(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
    .valid(va), .pixel(pa), .sof(sofa), .eol(eola), .eof(eofa), .busy(busya), .done(donea)
  );

  raster_pixel_source #(.PIX_W(4), .IMG_W(IW), .IMG_H(IH), .START_VAL(14)) dut_w (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
    .valid(vw), .pixel(pw), .sof(sofw), .eol(eolw), .eof(eofw), .busy(busyw), .done(donew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", tag, got, exp, $time, m_k);
    end
  endtask

  function automatic int exp_pix(input int md, input int k, input int w, input int sv);
    int r, c, m;
    r = k / IW;
    c = k % IW;
    m = 1 << w;
    case (md)
      0:       return (sv + k) % m;
      1:       return r % m;
      2:       return c % m;
      default: return (((r ^ c) & 1) != 0) ? m - 1 : 0;
    endcase
  endfunction

  task automatic check_all();
    int e_pa, e_pw, e_sof, e_eol, e_eof;
    e_pa  = m_run ? exp_pix(m_mode, m_k, 8, 1) : 0;
    e_pw  = m_run ? exp_pix(m_mode, m_k, 4, 14) : 0;
    e_sof = (m_run && m_k == 0) ? 1 : 0;
    e_eol = (m_run && (m_k % IW) == IW - 1) ? 1 : 0;
    e_eof = (m_run && m_k == NPIX - 1) ? 1 : 0;
    chk("valid_a", 32'(va), 32'(m_run));
    chk("pixel_a", 32'(pa), e_pa);
    chk("sof_a", 32'(sofa), e_sof);
    chk("eol_a", 32'(eola), e_eol);
    chk("eof_a", 32'(eofa), e_eof);
    chk("busy_a", 32'(busya), 32'(m_run));
    chk("done_a", 32'(donea), 32'(m_done));
    chk("valid_w", 32'(vw), 32'(m_run));
    chk("pixel_w", 32'(pw), e_pw);
    chk("sof_w", 32'(sofw), e_sof);
    chk("eol_w", 32'(eolw), e_eol);
    chk("eof_w", 32'(eofw), e_eof);
    chk("busy_w", 32'(busyw), 32'(m_run));
    chk("done_w", 32'(donew), 32'(m_done));
  endtask

  task automatic model_step(input bit st, input int md, input bit rdy);
    if (m_run) begin
      if (rdy) begin
        if (m_k == NPIX - 1) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end else begin
          m_k++;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (st) begin
      m_run  = 1'b1;
      m_k    = 0;
      m_mode = md;
    end
  endtask

  task automatic tick(input bit st, input int md, input bit rdy);
    start = st;
    mode  = 2'(md);
    ready = rdy;
    @(posedge clk);
    model_step(st, md, rdy);
    @(negedge clk);
    check_all();
    if (busya) cnt_busy++;
    if (donea) cnt_done++;
  endtask

  // pat: 0 ready always high, 1 ready 1,0,0,1 repeating, 2 random ready.
  function automatic bit ready_for(input int pat, input int cyc);
    case (pat)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_frame(input int md, input int pat);
    int cyc;
    cnt_busy = 0;
    cnt_done = 0;
    cyc = 0;
    tick(1'b1, md, ready_for(pat, cyc));
    while ((m_run || m_done) && cyc < 200) begin
      cyc++;
      tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ready_for(pat, cyc));
    end
    chk("frame_timeout", (m_run || m_done) ? 1 : 0, 0);
    chk("done_count", cnt_done, 1);
    if (pat == 0) chk("busy_cycles", cnt_busy, NPIX);
  endtask

  initial begin
    m_run = 1'b0; m_done = 1'b0; m_k = 0; m_mode = 0;
    start = 1'b0; ready = 1'b0; mode = 2'd0;
    rst = 1'b1;
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) tick(1'b0, 0, 1'b1);

    run_frame(0, 0);
    run_frame(0, 1);
    run_frame(1, 0);
    run_frame(2, 0);
    run_frame(3, 0);

    // Abandon a frame after five transfers; start during RUN must not restart it.
    tick(1'b1, 0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 3, 1'b1);
    chk("midframe_k", m_k, 5);
    #3;
    rst = 1'b1;
    #1;
    m_run = 1'b0; m_done = 1'b0; m_k = 0;
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b1);
    chk("no_done_after_reset", cnt_done, 0);
    run_frame(0, 0);

    for (int f = 0; f < 8; f++) begin
      int gap;
      run_frame(int'($urandom_range(0, 3)), 2);
      gap = int'($urandom_range(0, 2));
      for (int i = 0; i < gap; i++) tick(1'b0, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
